mac_mdc_v2: RTL

MAC_MDC_V2 -- requirements
Module: mac_mdc_v2

---
 rtl/mac_mdc_v2_pkg.sv | 40 ++++
 rtl/mac_mdc_v2_mult_stage.sv | 67 ++++++
 rtl/mac_mdc_v2.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_mdc_v2_pkg.sv
// -----------------------------------------------------------------------------
// mac_mdc_v2_package
// Shared types and defaults for the mac_mdc_v2 multiply / scalar-product block.
//   state_t         : controller states (IDLE, INIT, ACC, DRAIN, OUT)
//   mode_t          : operating modes selected by reg_mode
//   DEFAULT_CNT_LEN : default maximum scalar-product length
//   norm_mode()     : maps the raw 2-bit mode onto a supported mode
// -----------------------------------------------------------------------------
package mac_mdc_v2_package;

  localparam int DEFAULT_CNT_LEN = 4096;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_ACC   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_OUT   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    MODE_SIMPLE = 2'd0,
    MODE_ZERO   = 2'd1,
    MODE_C      = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_t;

  // The reserved encoding behaves like a scalar product started from zero.
  function automatic mode_t norm_mode(input logic [1:0] raw);
    mode_t m;
    case (raw)
      2'd0:    m = MODE_SIMPLE;
      2'd1:    m = MODE_ZERO;
      2'd2:    m = MODE_C;
      default: m = MODE_ZERO;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mac_mdc_v2_mult_stage.sv
// -----------------------------------------------------------------------------
// mac_mdc_v2_mult_stage
// Joins the a and b operand streams, multiplies them (signed) and holds the
// product in r_mult with a valid/ready handshake towards the consumer.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   enable                : controller permits new a/b handshakes
//   a_valid/a_ready/a_data: operand stream a
//   b_valid/b_ready/b_data: operand stream b
//   mult_valid/mult_ready : r_mult output handshake
//   r_mult                : registered signed product (2*DATA_WIDTH bits)
//   fire                  : a/b handshake happens this cycle
// -----------------------------------------------------------------------------
module mac_mdc_v2_mult_stage
  import mac_mdc_v2_package::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic                           a_valid,
  output logic                           a_ready,
  input  logic [DATA_WIDTH-1:0]          a_data,
  input  logic                           b_valid,
  output logic                           b_ready,
  input  logic [DATA_WIDTH-1:0]          b_data,
  output logic                           mult_valid,
  input  logic                           mult_ready,
  output logic signed [2*DATA_WIDTH-1:0] r_mult,
  output logic                           fire
);

  localparam int PROD_W = 2 * DATA_WIDTH;

  logic                     stage_ready;
  logic signed [PROD_W-1:0] a_ext;
  logic signed [PROD_W-1:0] b_ext;
  logic signed [PROD_W-1:0] product;

  assign a_ext   = PROD_W'($signed(a_data));
  assign b_ext   = PROD_W'($signed(b_data));
  assign product = a_ext * b_ext;

  // Join: both operands must be valid, and the product register must be free
  // or emptying this cycle, before either stream sees ready.
  always_comb begin
    stage_ready = enable & (~mult_valid | mult_ready);
    fire        = stage_ready & a_valid & b_valid;
    a_ready     = fire;
    b_ready     = fire;
  end

  // Product register: loads on a join, empties when consumed, holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mult_valid <= 1'b0;
      r_mult     <= {PROD_W{1'b0}};
    end else if (fire) begin
      mult_valid <= 1'b1;
      r_mult     <= product;
    end else if (mult_ready) begin
      mult_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mac_mdc_v2.sv
// -----------------------------------------------------------------------------
// mac_mdc_v2
// Streaming signed multiplier / scalar-product engine.
//   mode 0: d = (a*b) >>> shift, one result per cycle
//   mode 1: d = (sum a*b) >>> shift, accumulator starts at zero (mode 3 alike)
//   mode 2: d = ((c <<< shift) + sum a*b) >>> shift
// Optional build macro MAC_MDC_V2_SAT_EN: saturate d to the signed DATA_WIDTH
// range instead of truncating to the low bits.
// Ports:
//   ap_clk, ap_rst          : clock, asynchronous active-high reset
//   a_*/b_*                 : signed operand streams (AXI-Stream style)
//   c_*                     : signed accumulator-init stream (mode 2 only)
//   d_*                     : signed result stream
//   reg_mode/shift/len      : job configuration, captured when a job starts
//   busy                    : controller is not idle
// -----------------------------------------------------------------------------
module mac_mdc_v2
  import mac_mdc_v2_package::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_LEN    = DEFAULT_CNT_LEN,
  parameter int CNT_W      = $clog2(CNT_LEN) + 1,
  parameter int ACC_WIDTH  = 2 * DATA_WIDTH + $clog2(CNT_LEN)
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst,
  input  logic                          a_TVALID,
  output logic                          a_TREADY,
  input  logic [DATA_WIDTH-1:0]         a_TDATA,
  input  logic                          b_TVALID,
  output logic                          b_TREADY,
  input  logic [DATA_WIDTH-1:0]         b_TDATA,
  input  logic                          c_TVALID,
  output logic                          c_TREADY,
  input  logic [DATA_WIDTH-1:0]         c_TDATA,
  output logic                          d_TVALID,
  input  logic                          d_TREADY,
  output logic [DATA_WIDTH-1:0]         d_TDATA,
  input  logic [1:0]                    reg_mode,
  input  logic [$clog2(DATA_WIDTH)-1:0] reg_shift,
  input  logic [CNT_W-1:0]              reg_len,
  output logic                          busy
);

  localparam int               SHIFT_W = $clog2(DATA_WIDTH);
  localparam int               PROD_W  = 2 * DATA_WIDTH;
  localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(CNT_LEN - 1);

  // Reduce the wide shifted value to DATA_WIDTH bits.
  function automatic logic [DATA_WIDTH-1:0] fit_result(input logic signed [ACC_WIDTH-1:0] value);
    logic [DATA_WIDTH-1:0] result;
`ifdef MAC_MDC_V2_SAT_EN
    logic [ACC_WIDTH-DATA_WIDTH:0] upper;
    upper = value[ACC_WIDTH-1:DATA_WIDTH-1];
    // In range exactly when all bits from the DATA_WIDTH sign bit upward agree.
    if ((&upper) || (~|upper)) begin
      result = value[DATA_WIDTH-1:0];
    end else if (value[ACC_WIDTH-1]) begin
      result = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      result = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
`else
    result = value[DATA_WIDTH-1:0];
`endif
    return result;
  endfunction

  state_t                      state;
  state_t                      next_state;
  mode_t                       live_mode;
  mode_t                       cfg_mode;
  logic [SHIFT_W-1:0]          cfg_shift;
  logic [CNT_W-1:0]            cfg_len;
  logic [CNT_W-1:0]            len_clamped;
  logic [CNT_W-1:0]            r_cnt;
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic signed [ACC_WIDTH-1:0] c_ext;
  logic signed [ACC_WIDTH-1:0] mult_ext;
  logic signed [ACC_WIDTH-1:0] out_src;
  logic signed [ACC_WIDTH-1:0] out_shifted;
  logic signed [PROD_W-1:0]    r_mult;
  logic                        fsm_enable;
  logic                        mult_enable;
  logic                        mult_ready;
  logic                        mult_valid;
  logic                        mult_fire;
  logic                        ab_valid;
  logic                        len_zero;

  assign live_mode   = norm_mode(reg_mode);
  assign ab_valid    = a_TVALID & b_TVALID;
  assign len_clamped = (reg_len > LEN_MAX) ? LEN_MAX : reg_len;
  assign len_zero    = (cfg_len == {CNT_W{1'b0}});
  assign c_ext       = ACC_WIDTH'($signed(c_TDATA));
  assign mult_ext    = ACC_WIDTH'(r_mult);
  // Keep operand readies low while reset is applied.
  assign mult_enable = fsm_enable & ~ap_rst;
  assign busy        = (state != ST_IDLE);

  mac_mdc_v2_mult_stage #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mult_stage (
    .clk        (ap_clk),
    .rst        (ap_rst),
    .enable     (mult_enable),
    .a_valid    (a_TVALID),
    .a_ready    (a_TREADY),
    .a_data     (a_TDATA),
    .b_valid    (b_TVALID),
    .b_ready    (b_TREADY),
    .b_data     (b_TDATA),
    .mult_valid (mult_valid),
    .mult_ready (mult_ready),
    .r_mult     (r_mult),
    .fire       (mult_fire)
  );

  // Controller state register.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Controller next state and handshake controls.
  always_comb begin
    next_state = state;
    fsm_enable = 1'b0;
    mult_ready = 1'b0;
    c_TREADY   = 1'b0;
    d_TVALID   = 1'b0;
    case (state)
      ST_IDLE: begin
        // Simple mode streams straight through r_mult to d while idle.
        fsm_enable = (live_mode == MODE_SIMPLE);
        mult_ready = d_TREADY;
        d_TVALID   = mult_valid;
        // A scalar job may only start once any simple-mode result has left.
        if ((live_mode != MODE_SIMPLE) && !mult_valid &&
            (ab_valid || ((live_mode == MODE_C) && c_TVALID))) begin
          next_state = ST_INIT;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_INIT: begin
        if (cfg_mode == MODE_C) begin
          c_TREADY = 1'b1;
          if (c_TVALID) begin
            next_state = len_zero ? ST_OUT : ST_ACC;
          end else begin
            next_state = ST_INIT;
          end
        end else begin
          next_state = len_zero ? ST_OUT : ST_ACC;
        end
      end
      ST_ACC: begin
        fsm_enable = (r_cnt < cfg_len);
        mult_ready = 1'b1;
        if (r_cnt == cfg_len) begin
          next_state = ST_DRAIN;
        end else begin
          next_state = ST_ACC;
        end
      end
      ST_DRAIN: begin
        mult_ready = 1'b1;
        if (!mult_valid) begin
          next_state = ST_OUT;
        end else begin
          next_state = ST_DRAIN;
        end
      end
      ST_OUT: begin
        d_TVALID = 1'b1;
        if (d_TREADY) begin
          next_state = ST_IDLE;
        end else begin
          next_state = ST_OUT;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Job configuration, product counter and accumulator.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      cfg_mode  <= MODE_SIMPLE;
      cfg_shift <= {SHIFT_W{1'b0}};
      cfg_len   <= {CNT_W{1'b0}};
      r_cnt     <= {CNT_W{1'b0}};
      r_acc     <= {ACC_WIDTH{1'b0}};
    end else begin
      case (state)
        ST_IDLE: begin
          if (next_state == ST_INIT) begin
            cfg_mode  <= live_mode;
            cfg_shift <= reg_shift;
            cfg_len   <= len_clamped;
          end else if (mult_fire) begin
            // Simple mode: the shift travels with the product it applies to.
            cfg_shift <= reg_shift;
          end
        end
        ST_INIT: begin
          r_cnt <= {CNT_W{1'b0}};
          if (cfg_mode == MODE_C) begin
            if (c_TVALID) begin
              r_acc <= c_ext <<< cfg_shift;
            end
          end else begin
            r_acc <= {ACC_WIDTH{1'b0}};
          end
        end
        ST_ACC, ST_DRAIN: begin
          if (mult_fire) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
          if (mult_valid) begin
            r_acc <= r_acc + mult_ext;
          end
        end
        ST_OUT: begin
          if (d_TREADY) begin
            r_cnt <= {CNT_W{1'b0}};
          end
        end
        default: begin
          r_cnt <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Result path: accumulator in OUT, simple-mode product while idle.
  always_comb begin
    case (state)
      ST_OUT:  out_src = r_acc;
      ST_IDLE: out_src = mult_ext;
      default: out_src = {ACC_WIDTH{1'b0}};
    endcase
    out_shifted = out_src >>> cfg_shift;
    d_TDATA     = fit_result(out_shifted);
  end

endmodule
